// File: rtl/counter_carry_extender_pkg.sv
// Shared encodings for stages that consume the 3-bit T-flip-flop counter.
package counter_carry_extender_pkg;

  localparam int unsigned COUNT_BITS = 3;
  localparam logic [COUNT_BITS-1:0] COUNT_MAX = 3'd7;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/counter_carry_extender_step_checker.sv
// Classifies one counter transition prev->cur as increment, hold or 7->0 wrap.
module counter_carry_extender_step_checker
  import counter_carry_extender_pkg::*;
(
  input  logic [COUNT_BITS-1:0] prev,
  input  logic [COUNT_BITS-1:0] cur,
  output logic                  is_inc,
  output logic                  is_hold,
  output logic                  is_wrap
);

  logic [COUNT_BITS-1:0] prev_plus_one;

  always_comb begin
    prev_plus_one = prev + 1'b1;
    is_inc        = (cur == prev_plus_one);
    is_hold       = (cur == prev);
    is_wrap       = (prev == COUNT_MAX) && (cur == '0);
  end

endmodule

// File: rtl/counter_carry_extender.sv
// Extends the 3-bit counter with an upper-order wrap count and a sequence
// checker that latches a fault on any step other than +1 or hold.
module counter_carry_extender
  import counter_carry_extender_pkg::*;
#(
  parameter int unsigned HI_WIDTH  = 5,
  parameter int unsigned ERR_WIDTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           a,
  input  logic                           b,
  input  logic                           c,
  input  logic                           clear,
  output logic                           carry,
  output logic [HI_WIDTH-1:0]            hi_count,
  output logic [HI_WIDTH+COUNT_BITS-1:0] full_count,
  output logic                           valid,
  output logic                           hi_ovf,
  output logic                           seq_err,
  output logic [ERR_WIDTH-1:0]           err_count
);

  state_t                state;
  logic [COUNT_BITS-1:0] cur;
  logic [COUNT_BITS-1:0] prev;
  logic                  is_inc;
  logic                  is_hold;
  logic                  is_wrap;
  logic                  is_illegal;

  assign cur        = {c, b, a};
  assign is_illegal = !(is_inc || is_hold);
  assign full_count = {hi_count, prev};

  counter_carry_extender_step_checker u_step_checker (
    .prev    (prev),
    .cur     (cur),
    .is_inc  (is_inc),
    .is_hold (is_hold),
    .is_wrap (is_wrap)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= PRIME;
      prev      <= '0;
      carry     <= 1'b0;
      hi_count  <= '0;
      valid     <= 1'b0;
      hi_ovf    <= 1'b0;
      seq_err   <= 1'b0;
      err_count <= '0;
    end else begin
      // prev follows cur in every state, so FAULT keeps judging each new step
      prev  <= cur;
      carry <= 1'b0;
      if (clear) begin
        state     <= PRIME;
        hi_count  <= '0;
        valid     <= 1'b0;
        hi_ovf    <= 1'b0;
        seq_err   <= 1'b0;
        err_count <= '0;
      end else begin
        case (state)
          PRIME: begin
            state <= TRACK;
            valid <= 1'b1;
          end
          TRACK: begin
            if (is_wrap) begin
              carry    <= 1'b1;
              hi_count <= hi_count + 1'b1;
              if (&hi_count) hi_ovf <= 1'b1;
            end else if (is_illegal) begin
              state   <= FAULT;
              valid   <= 1'b0;
              seq_err <= 1'b1;
              if (!(&err_count)) err_count <= err_count + 1'b1;
            end
          end
          FAULT: begin
            if (is_illegal && !(&err_count)) err_count <= err_count + 1'b1;
          end
          default: begin
            state <= PRIME;
            valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
